mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/mod_counter.sv | 96 +++++++++
 tb/tb_mod_counter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with load, clear, cascadable terminal count
// and a sticky wrap-around flag.
module mod_counter #(
  parameter int unsigned     WIDTH   = 32'd4,
  parameter longint unsigned MODULUS = 64'd16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  // Largest legal count value, and the modulus widened by one bit so that
  // MODULUS = 2^WIDTH is still representable for the load range check.
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 32'd1)'(MODULUS);
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(32'd1);

  logic [WIDTH-1:0] count_r;
  logic             wrapped_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             wrapped_nxt_s;
  logic             at_max_s;
  logic             at_zero_s;
  logic             load_over_s;
  logic             wrap_s;

  assign at_max_s    = (count_r == MAX_VAL);
  assign at_zero_s   = (count_r == ZERO_VAL);
  assign load_over_s = ({1'b0, load_val} >= MOD_EXT);

  // A wrap happens on this edge only when counting is the winning action
  // and the count sits at the end of the sequence for the current direction.
  assign wrap_s = en & ~clear & ~load & ((up_dn & at_max_s) | (~up_dn & at_zero_s));

  // Terminal count is combinational for zero-latency cascading, but must
  // read 0 while reset is held (count=0 would otherwise flag a down borrow).
  assign tc = wrap_s & reset;

  assign count   = count_r;
  assign wrapped = wrapped_r;

  // Next-state selection with fixed priority clear > load > en > hold.
  always_comb begin
    count_nxt_s   = count_r;
    wrapped_nxt_s = wrapped_r;
    if (clear) begin
      count_nxt_s   = ZERO_VAL;
      wrapped_nxt_s = 1'b0;
    end else if (load) begin
      if (load_over_s) begin
        count_nxt_s = MAX_VAL;
      end else begin
        count_nxt_s = load_val;
      end
    end else if (en) begin
      if (up_dn) begin
        if (at_max_s) begin
          count_nxt_s   = ZERO_VAL;
          wrapped_nxt_s = 1'b1;
        end else begin
          count_nxt_s = count_r + ONE_VAL;
        end
      end else begin
        if (at_zero_s) begin
          count_nxt_s   = MAX_VAL;
          wrapped_nxt_s = 1'b1;
        end else begin
          count_nxt_s = count_r - ONE_VAL;
        end
      end
    end else begin
      count_nxt_s   = count_r;
      wrapped_nxt_s = wrapped_r;
    end
  end

  // Count and sticky wrap flag registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r   <= ZERO_VAL;
      wrapped_r <= 1'b0;
    end else begin
      count_r   <= count_nxt_s;
      wrapped_r <= wrapped_nxt_s;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: a MODULUS=10 main instance driven
// through a reference model and scoreboard, a power-of-two instance, and
// a two-stage decade cascade.
module tb_mod_counter;

  logic       clk;
  logic       reset;
  logic       en, up_dn, clear, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc, wrapped;

  logic       p_en, p_up_dn;
  logic [2:0] p_count;
  logic       p_tc, p_wrapped;

  logic       cas_en;
  logic [3:0] c1_count, c2_count;
  logic       c1_tc, c2_tc, c1_wrapped, c2_wrapped;

  typedef struct {
    logic [3:0] cnt;
    logic       wr;
  } exp_t;

  typedef struct {
    logic [3:0] lo;
    logic [3:0] hi;
  } cas_t;

  exp_t sb[$];
  cas_t cas_sb[$];

  logic [3:0] m_cnt;
  logic       m_wr;
  logic       exp_tc;

  int total;
  int bad;

  mod_counter #(.WIDTH(32'd4), .MODULUS(64'd10)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val), .count(count), .tc(tc), .wrapped(wrapped)
  );

  mod_counter #(.WIDTH(32'd3), .MODULUS(64'd8)) dut_p (
    .clk(clk), .reset(reset), .en(p_en), .up_dn(p_up_dn), .clear(1'b0),
    .load(1'b0), .load_val(3'd0), .count(p_count), .tc(p_tc), .wrapped(p_wrapped)
  );

  mod_counter #(.WIDTH(32'd4), .MODULUS(64'd10)) dut_c1 (
    .clk(clk), .reset(reset), .en(cas_en), .up_dn(1'b1), .clear(1'b0),
    .load(1'b0), .load_val(4'd0), .count(c1_count), .tc(c1_tc), .wrapped(c1_wrapped)
  );

  mod_counter #(.WIDTH(32'd4), .MODULUS(64'd10)) dut_c2 (
    .clk(clk), .reset(reset), .en(c1_tc), .up_dn(1'b1), .clear(1'b0),
    .load(1'b0), .load_val(4'd0), .count(c2_count), .tc(c2_tc), .wrapped(c2_wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive main-instance controls, advance the reference model and queue the
  // state expected after the coming edge.
  task automatic drive(input logic c, input logic l, input logic [3:0] lv,
                       input logic e, input logic ud);
    exp_t x;
    clear = c; load = l; load_val = lv; en = e; up_dn = ud;
    exp_tc = e & ~c & ~l & ((ud && m_cnt == 4'd9) || (!ud && m_cnt == 4'd0));
    if (c) begin
      m_cnt = 4'd0;
      m_wr  = 1'b0;
    end else if (l) begin
      m_cnt = (lv >= 4'd10) ? 4'd9 : lv;
    end else if (e) begin
      if (ud) begin
        if (m_cnt == 4'd9) begin m_cnt = 4'd0; m_wr = 1'b1; end
        else m_cnt = m_cnt + 4'd1;
      end else begin
        if (m_cnt == 4'd0) begin m_cnt = 4'd9; m_wr = 1'b1; end
        else m_cnt = m_cnt - 4'd1;
      end
    end
    x.cnt = m_cnt;
    x.wr  = m_wr;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en = 1'b1; up_dn = 1'b0; clear = 1'b0; load = 1'b0; load_val = 4'd0;
    p_en = 1'b0; p_up_dn = 1'b1; cas_en = 1'b0;
    #12;
    total++;
    if (count !== 4'd0 || wrapped !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: count=%0d wrapped=%0b, required count=0 wrapped=0", count, wrapped);
    end
    total++;
    if (tc !== 1'b0) begin
      bad++;
      $display("FAIL reset_tc: tc=%0b, required 0", tc);
    end
    @(negedge clk);
    reset = 1'b1;
    m_cnt = 4'd0;
    m_wr  = 1'b0;
  endtask

  task automatic test_up_wrap();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      #1;
      total++;
      if (tc !== exp_tc) begin
        bad++;
        $display("FAIL up_tc step %0d: tc=%0b, required %0b", i, tc, exp_tc);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (count !== e.cnt || wrapped !== e.wr) begin
        bad++;
        $display("FAIL up_count step %0d: count=%0d wrapped=%0b, required %0d/%0b", i, count, wrapped, e.cnt, e.wr);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (count !== e.cnt || wrapped !== e.wr) begin
        bad++;
        $display("FAIL pre_reset_count step %0d: count=%0d wrapped=%0b, required %0d/%0b", i, count, wrapped, e.cnt, e.wr);
      end
    end
    @(negedge clk);
    up_dn = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (count !== 4'd0 || wrapped !== 1'b0 || tc !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: count=%0d wrapped=%0b tc=%0b, required 0/0/0", count, wrapped, tc);
    end
    reset = 1'b1;
    m_cnt = 4'd0;
    m_wr  = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (count !== e.cnt || wrapped !== e.wr) begin
      bad++;
      $display("FAIL first_edge_after_reset: count=%0d wrapped=%0b, required %0d/%0b", count, wrapped, e.cnt, e.wr);
    end
  endtask

  task automatic test_down_wrap();
    exp_t e;
    drive(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (count !== e.cnt || wrapped !== e.wr) begin
      bad++;
      $display("FAIL load_2: count=%0d wrapped=%0b, required %0d/%0b", count, wrapped, e.cnt, e.wr);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      #1;
      total++;
      if (tc !== exp_tc) begin
        bad++;
        $display("FAIL down_tc step %0d: tc=%0b, required %0b", i, tc, exp_tc);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (count !== e.cnt || wrapped !== e.wr) begin
        bad++;
        $display("FAIL down_count step %0d: count=%0d wrapped=%0b, required %0d/%0b", i, count, wrapped, e.cnt, e.wr);
      end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    // Saturating load while wrapped is set: wrapped must survive.
    drive(1'b0, 1'b1, 4'd12, 1'b1, 1'b1);
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (count !== e.cnt || wrapped !== e.wr) begin
      bad++;
      $display("FAIL load_saturate: count=%0d wrapped=%0b, required %0d/%0b", count, wrapped, e.cnt, e.wr);
    end
    // Clear beats load and enable.
    drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
    #1;
    total++;
    if (tc !== exp_tc) begin
      bad++;
      $display("FAIL clear_tc: tc=%0b, required %0b", tc, exp_tc);
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (count !== e.cnt || wrapped !== e.wr) begin
      bad++;
      $display("FAIL clear_priority: count=%0d wrapped=%0b, required %0d/%0b", count, wrapped, e.cnt, e.wr);
    end
    // Load beats enable.
    drive(1'b0, 1'b1, 4'd7, 1'b1, 1'b1);
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (count !== e.cnt || wrapped !== e.wr) begin
      bad++;
      $display("FAIL load_over_en: count=%0d wrapped=%0b, required %0d/%0b", count, wrapped, e.cnt, e.wr);
    end
  endtask

  task automatic test_enable_gating();
    exp_t e;
    logic dirs [3];
    dirs[0] = 1'b1; dirs[1] = 1'b0; dirs[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      #1;
      total++;
      if (tc !== 1'b0) begin
        bad++;
        $display("FAIL hold_tc step %0d: tc=%0b, required 0", i, tc);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (count !== e.cnt || wrapped !== e.wr) begin
        bad++;
        $display("FAIL hold_count step %0d: count=%0d wrapped=%0b, required %0d/%0b", i, count, wrapped, e.cnt, e.wr);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, dirs[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (count !== e.cnt || wrapped !== e.wr) begin
        bad++;
        $display("FAIL toggle_dir step %0d: count=%0d wrapped=%0b, required %0d/%0b", i, count, wrapped, e.cnt, e.wr);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_pow2();
    logic [2:0] exp_c;
    exp_c = 3'd0;
    p_up_dn = 1'b1;
    p_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      exp_c = exp_c + 3'd1;
      total++;
      if (p_count !== exp_c) begin
        bad++;
        $display("FAIL pow2_up step %0d: count=%0d, required %0d", i, p_count, exp_c);
      end
    end
    total++;
    if (p_wrapped !== 1'b1) begin
      bad++;
      $display("FAIL pow2_wrapped: wrapped=%0b, required 1", p_wrapped);
    end
    p_up_dn = 1'b0;
    #1;
    total++;
    if (p_tc !== 1'b1) begin
      bad++;
      $display("FAIL pow2_borrow_tc: tc=%0b, required 1", p_tc);
    end
    @(posedge clk); #1;
    total++;
    if (p_count !== 3'd7) begin
      bad++;
      $display("FAIL pow2_down: count=%0d, required 7", p_count);
    end
    p_en = 1'b0;
  endtask

  task automatic test_cascade();
    cas_t x;
    for (int n = 0; n < 100; n++) begin
      cas_en = 1'b1;
      x.lo = 4'((n + 1) % 10);
      x.hi = 4'(((n + 1) / 10) % 10);
      cas_sb.push_back(x);
      #1;
      total++;
      if (c1_tc !== ((n % 10) == 9)) begin
        bad++;
        $display("FAIL cascade_tc1 n=%0d: tc=%0b, required %0b", n, c1_tc, ((n % 10) == 9));
      end
      if (n == 99) begin
        total++;
        if (c1_tc !== 1'b1 || c2_tc !== 1'b1 || c2_wrapped !== 1'b0) begin
          bad++;
          $display("FAIL cascade_99: tc1=%0b tc2=%0b wrapped2=%0b, required 1/1/0", c1_tc, c2_tc, c2_wrapped);
        end
      end
      @(posedge clk); #1;
      x = cas_sb.pop_front();
      total++;
      if (c1_count !== x.lo || c2_count !== x.hi) begin
        bad++;
        $display("FAIL cascade_count n=%0d: %0d%0d, required %0d%0d", n + 1, c2_count, c1_count, x.hi, x.lo);
      end
    end
    cas_en = 1'b0;
    total++;
    if (c2_wrapped !== 1'b1 || c1_wrapped !== 1'b1) begin
      bad++;
      $display("FAIL cascade_wrapped: wrapped1=%0b wrapped2=%0b, required 1/1", c1_wrapped, c2_wrapped);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_up_wrap();
    test_async_reset();
    test_down_wrap();
    test_priority();
    test_enable_gating();
    test_pow2();
    test_cascade();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
